// File: rtl/brew_pkg.sv
// Shared definitions for the brew sequencer: state encoding, drink codes
// and the default phase durations in divider ticks.
package brew_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CHECK   = 3'd1,
        ST_PRESS   = 3'd2,
        ST_HEAT    = 3'd3,
        ST_DELIVER = 3'd4,
        ST_DONE    = 3'd5,
        ST_FAULT   = 3'd6
    } state_t;

    typedef enum logic [1:0] {
        DRINK_ESPRESSO = 2'd0,
        DRINK_LONG     = 2'd1,
        DRINK_MILK     = 2'd2,
        DRINK_DOUBLE   = 2'd3
    } drink_t;

    localparam int DEF_CNT_W   = 4;
    localparam int DEF_PRESS_T = 3;
    localparam int DEF_HEAT_T0 = 2;
    localparam int DEF_HEAT_T1 = 3;
    localparam int DEF_HEAT_T2 = 4;
    localparam int DEF_HEAT_T3 = 5;
    localparam int DEF_DELIV_T = 4;

endpackage

// File: rtl/brew_sequencer_phase_timer.sv
// Down-counter measuring one brew phase in ticks; a zero load becomes 1 so
// that no phase can be skipped.
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             tick,
    output logic             expire
);

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = (load_val == '0) ? ONE : load_val;
        end else if (run && tick && (count_q != '0)) begin
            count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expire = run & tick & (count_q == ONE);

endmodule

// File: rtl/brew_sequencer.sv
// Sequences one drink order: sensor check, pressurize, heat, deliver, done,
// with abort-to-FAULT and a refund pulse on sensor loss.
module brew_sequencer
    import brew_pkg::*;
#(
    parameter int CNT_W   = DEF_CNT_W,
    parameter int PRESS_T = DEF_PRESS_T,
    parameter int HEAT_T0 = DEF_HEAT_T0,
    parameter int HEAT_T1 = DEF_HEAT_T1,
    parameter int HEAT_T2 = DEF_HEAT_T2,
    parameter int HEAT_T3 = DEF_HEAT_T3,
    parameter int DELIV_T = DEF_DELIV_T
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [1:0] drink,
    input  logic       water_ok,
    input  logic       grain_ok,
    input  logic       cup_ok,
    input  logic       fault_clr,
    output logic       busy,
    output logic       press_on,
    output logic       heat_on,
    output logic       deliver_on,
    output logic       done,
    output logic       refund,
    output logic       fault,
    output logic [2:0] state
);

    localparam logic [CNT_W-1:0] PRESS_L = PRESS_T[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HEAT_L0 = HEAT_T0[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HEAT_L1 = HEAT_T1[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HEAT_L2 = HEAT_T2[CNT_W-1:0];
    localparam logic [CNT_W-1:0] HEAT_L3 = HEAT_T3[CNT_W-1:0];
    localparam logic [CNT_W-1:0] DELIV_L = DELIV_T[CNT_W-1:0];

    state_t           state_q, state_d;
    logic [1:0]       drink_q, drink_d;
    logic             busy_q, busy_d;
    logic             press_on_q, press_on_d;
    logic             heat_on_q, heat_on_d;
    logic             deliver_on_q, deliver_on_d;
    logic             done_q, done_d;
    logic             refund_q, refund_d;
    logic             fault_q, fault_d;

    logic             sens_ok;
    logic             run;
    logic             load;
    logic [CNT_W-1:0] load_val;
    logic [CNT_W-1:0] heat_val;
    logic             expire;

    assign sens_ok = water_ok & grain_ok & cup_ok;
    assign run = (state_q == ST_PRESS) || (state_q == ST_HEAT) || (state_q == ST_DELIVER);

    always_comb begin
        heat_val = HEAT_L0;
        case (drink_q)
            DRINK_ESPRESSO: heat_val = HEAT_L0;
            DRINK_LONG:     heat_val = HEAT_L1;
            DRINK_MILK:     heat_val = HEAT_L2;
            DRINK_DOUBLE:   heat_val = HEAT_L3;
            default:        heat_val = HEAT_L0;
        endcase
    end

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk      (clk),
        .rst      (rst),
        .run      (run),
        .load     (load),
        .load_val (load_val),
        .tick     (tick),
        .expire   (expire)
    );

    // Sensor loss is tested ahead of timer expiry so an abort always wins.
    always_comb begin
        state_d  = state_q;
        drink_d  = drink_q;
        load     = 1'b0;
        load_val = '0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_CHECK;
                    drink_d = drink;
                end
            end
            ST_CHECK: begin
                if (sens_ok) begin
                    state_d  = ST_PRESS;
                    load     = 1'b1;
                    load_val = PRESS_L;
                end else begin
                    state_d = ST_FAULT;
                end
            end
            ST_PRESS: begin
                if (!sens_ok) begin
                    state_d = ST_FAULT;
                end else if (expire) begin
                    state_d  = ST_HEAT;
                    load     = 1'b1;
                    load_val = heat_val;
                end
            end
            ST_HEAT: begin
                if (!sens_ok) begin
                    state_d = ST_FAULT;
                end else if (expire) begin
                    state_d  = ST_DELIVER;
                    load     = 1'b1;
                    load_val = DELIV_L;
                end
            end
            ST_DELIVER: begin
                if (!cup_ok) begin
                    state_d = ST_FAULT;
                end else if (expire) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            ST_FAULT: begin
                if (fault_clr && sens_ok) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs decode the next state so they line up exactly with state_q.
    always_comb begin
        busy_d       = (state_d != ST_IDLE);
        press_on_d   = (state_d == ST_PRESS);
        heat_on_d    = (state_d == ST_HEAT);
        deliver_on_d = (state_d == ST_DELIVER);
        done_d       = (state_d == ST_DONE);
        fault_d      = (state_d == ST_FAULT);
        refund_d     = (state_d == ST_FAULT) && (state_q != ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            drink_q      <= '0;
            busy_q       <= 1'b0;
            press_on_q   <= 1'b0;
            heat_on_q    <= 1'b0;
            deliver_on_q <= 1'b0;
            done_q       <= 1'b0;
            refund_q     <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            drink_q      <= drink_d;
            busy_q       <= busy_d;
            press_on_q   <= press_on_d;
            heat_on_q    <= heat_on_d;
            deliver_on_q <= deliver_on_d;
            done_q       <= done_d;
            refund_q     <= refund_d;
            fault_q      <= fault_d;
        end
    end

    assign busy       = busy_q;
    assign press_on   = press_on_q;
    assign heat_on    = heat_on_q;
    assign deliver_on = deliver_on_q;
    assign done       = done_q;
    assign refund     = refund_q;
    assign fault      = fault_q;
    assign state      = state_q;

endmodule

// File: tb/tb_brew_sequencer.sv
// Directed bench for brew_sequencer, plus a second instance with a zero
// espresso heat time and a random run guarding actuator exclusivity.
module tb_brew_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [1:0] drink = 2'd0;
    logic       water_ok = 1'b1;
    logic       grain_ok = 1'b1;
    logic       cup_ok = 1'b1;
    logic       fault_clr = 1'b0;

    logic       busy, press_on, heat_on, deliver_on, done, refund, fault;
    logic [2:0] state;
    logic       busy_z, press_on_z, heat_on_z, deliver_on_z, done_z, refund_z, fault_z;
    logic [2:0] state_z;

    int n_checks = 0;
    int n_pass = 0;
    int press_ticks = 0, heat_ticks = 0, deliv_ticks = 0, heat_z_ticks = 0;
    int done_cnt = 0, refund_cnt = 0, excl_viol = 0;

    brew_sequencer dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .drink(drink),
        .water_ok(water_ok), .grain_ok(grain_ok), .cup_ok(cup_ok), .fault_clr(fault_clr),
        .busy(busy), .press_on(press_on), .heat_on(heat_on), .deliver_on(deliver_on),
        .done(done), .refund(refund), .fault(fault), .state(state)
    );

    brew_sequencer #(.HEAT_T0(0)) dut_z (
        .clk(clk), .rst(rst), .tick(tick), .start(start), .drink(drink),
        .water_ok(water_ok), .grain_ok(grain_ok), .cup_ok(cup_ok), .fault_clr(fault_clr),
        .busy(busy_z), .press_on(press_on_z), .heat_on(heat_on_z), .deliver_on(deliver_on_z),
        .done(done_z), .refund(refund_z), .fault(fault_z), .state(state_z)
    );

    always #5 clk = ~clk;

    // Counts ticks seen by each phase and output pulses, just after inputs settle.
    always @(negedge clk) begin
        #2;
        if (press_on === 1'b1 && tick === 1'b1) press_ticks++;
        if (heat_on === 1'b1 && tick === 1'b1) heat_ticks++;
        if (deliver_on === 1'b1 && tick === 1'b1) deliv_ticks++;
        if (heat_on_z === 1'b1 && tick === 1'b1) heat_z_ticks++;
        if (done === 1'b1) done_cnt++;
        if (refund === 1'b1) refund_cnt++;
        if ($countones({press_on, heat_on, deliver_on}) > 1 ||
            $countones({press_on_z, heat_on_z, deliver_on_z}) > 1) excl_viol++;
        assert ($countones({press_on, heat_on, deliver_on}) <= 1)
            else $error("[TB] actuator exclusivity broken in dut");
        assert ($countones({press_on_z, heat_on_z, deliver_on_z}) <= 1)
            else $error("[TB] actuator exclusivity broken in dut_z");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One tick every 4 clocks.
    task automatic tickWait(input int n);
        repeat (n) begin
            repeat (3) @(negedge clk);
            tick = 1'b1;
            @(negedge clk);
            tick = 1'b0;
        end
    endtask

    task automatic applyStimulus(input logic [1:0] d);
        @(negedge clk);
        drink = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drink = ~d;
    endtask

    task automatic runUntilIdle(input int max_ticks);
        int k = 0;
        while (busy === 1'b1 && k < max_ticks) begin
            tickWait(1);
            k++;
        end
        checkOutput("idle_reached", {31'd0, busy}, 32'd0);
    endtask

    task automatic clearFault();
        water_ok = 1'b1;
        grain_ok = 1'b1;
        cup_ok = 1'b1;
        @(negedge clk);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
    endtask

    function automatic logic [6:0] outVec();
        return {busy, press_on, heat_on, deliver_on, done, refund, fault};
    endfunction

    int p0, h0, d0, dn0, r0, hz0;

    task automatic snapshot();
        p0 = press_ticks; h0 = heat_ticks; d0 = deliv_ticks;
        dn0 = done_cnt; r0 = refund_cnt; hz0 = heat_z_ticks;
    endtask

    initial begin
        // Reset dominates a simultaneous start.
        start = 1'b1;
        cycles(3);
        checkOutput("reset_state", state, 3'd0);
        checkOutput("reset_outputs", outVec(), 7'd0);
        rst = 1'b0;
        start = 1'b0;
        cycles(2);
        checkOutput("idle_after_reset", state, 3'd0);

        // Nominal brew, drink 2.
        snapshot();
        applyStimulus(2'd2);
        checkOutput("nom_check_state", state, 3'd1);
        cycles(1);
        checkOutput("nom_press_state", state, 3'd2);
        checkOutput("nom_press_out", outVec(), 7'b1100000);
        runUntilIdle(40);
        checkOutput("nom_press_ticks", press_ticks - p0, 3);
        checkOutput("nom_heat_ticks", heat_ticks - h0, 4);
        checkOutput("nom_deliv_ticks", deliv_ticks - d0, 4);
        checkOutput("nom_done_pulses", done_cnt - dn0, 1);
        checkOutput("nom_refund_pulses", refund_cnt - r0, 0);

        // Cup missing at order.
        snapshot();
        cup_ok = 1'b0;
        applyStimulus(2'd1);
        checkOutput("miss_check_state", state, 3'd1);
        cycles(1);
        checkOutput("miss_fault_state", state, 3'd6);
        checkOutput("miss_fault_out", outVec(), 7'b1000011);
        cycles(1);
        checkOutput("miss_refund_single", {31'd0, refund}, 32'd0);
        @(negedge clk); fault_clr = 1'b1;
        @(negedge clk); fault_clr = 1'b0;
        checkOutput("miss_clr_blocked", state, 3'd6);
        cup_ok = 1'b1;
        @(negedge clk); fault_clr = 1'b1; start = 1'b1;
        @(negedge clk); fault_clr = 1'b0; start = 1'b0;
        checkOutput("miss_clr_idle", state, 3'd0);
        cycles(1);
        checkOutput("miss_start_dropped", state, 3'd0);
        checkOutput("miss_refund_pulses", refund_cnt - r0, 1);

        // Water lost on the second heat tick of drink 3.
        applyStimulus(2'd3);
        cycles(1);
        tickWait(3);
        checkOutput("abort_in_heat", state, 3'd3);
        tickWait(1);
        repeat (3) @(negedge clk);
        tick = 1'b1; water_ok = 1'b0;
        @(negedge clk); tick = 1'b0;
        checkOutput("abort_state", state, 3'd6);
        checkOutput("abort_out", outVec(), 7'b1000011);
        clearFault();
        checkOutput("abort_cleared", state, 3'd0);

        // Water lost exactly on heat expiry: FAULT, never DELIVER.
        applyStimulus(2'd3);
        cycles(1);
        tickWait(3);
        tickWait(4);
        repeat (3) @(negedge clk);
        tick = 1'b1; water_ok = 1'b0;
        @(negedge clk); tick = 1'b0;
        checkOutput("coincide_state", state, 3'd6);
        checkOutput("coincide_deliver", {31'd0, deliver_on}, 32'd0);
        clearFault();

        // In DELIVER only the cup sensor aborts.
        applyStimulus(2'd1);
        cycles(1);
        tickWait(3);
        tickWait(3);
        checkOutput("deliv_entered", state, 3'd4);
        water_ok = 1'b0; grain_ok = 1'b0;
        tickWait(1);
        checkOutput("deliv_ignores_water", state, 3'd4);
        cup_ok = 1'b0;
        @(negedge clk);
        checkOutput("deliv_cup_abort", outVec(), 7'b1000011);
        clearFault();

        // Second start during PRESS is ignored.
        snapshot();
        applyStimulus(2'd1);
        cycles(1);
        tickWait(1);
        @(negedge clk); start = 1'b1; drink = 2'd0;
        @(negedge clk); start = 1'b0;
        runUntilIdle(40);
        checkOutput("busy_press_ticks", press_ticks - p0, 3);
        checkOutput("busy_heat_ticks", heat_ticks - h0, 3);
        cycles(20);
        checkOutput("busy_done_pulses", done_cnt - dn0, 1);

        // Reset during DELIVER.
        applyStimulus(2'd0);
        cycles(1);
        tickWait(3);
        tickWait(2);
        checkOutput("rst_in_deliver", state, 3'd4);
        tickWait(1);
        snapshot();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        checkOutput("rst_state", state, 3'd0);
        checkOutput("rst_outputs", outVec(), 7'd0);
        checkOutput("rst_state_z", state_z, 3'd0);
        cycles(3);
        checkOutput("rst_no_pulses", (done_cnt - dn0) + (refund_cnt - r0), 0);
        snapshot();
        applyStimulus(2'd2);
        cycles(1);
        runUntilIdle(40);
        checkOutput("rst_rebrew_heat", heat_ticks - h0, 4);
        checkOutput("rst_rebrew_deliv", deliv_ticks - d0, 4);
        checkOutput("rst_rebrew_done", done_cnt - dn0, 1);

        // Zero heat time is forced to a single tick.
        snapshot();
        applyStimulus(2'd0);
        cycles(1);
        runUntilIdle(40);
        checkOutput("zero_heat_z_ticks", heat_z_ticks - hz0, 1);
        checkOutput("espresso_heat_ticks", heat_ticks - h0, 2);

        // Random ticks, sensors and commands.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            tick      = ($urandom_range(3) == 0);
            start     = ($urandom_range(7) == 0);
            fault_clr = ($urandom_range(7) == 0);
            drink     = 2'($urandom_range(3));
            water_ok  = ($urandom_range(31) != 0);
            grain_ok  = ($urandom_range(31) != 0);
            cup_ok    = ($urandom_range(31) != 0);
        end
        @(negedge clk);
        tick = 1'b0; start = 1'b0; fault_clr = 1'b0;
        water_ok = 1'b1; grain_ok = 1'b1; cup_ok = 1'b1;
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        cycles(2);
        checkOutput("exclusivity_violations", excl_viol, 0);
        checkOutput("final_reset_state", state, 3'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/brew_sequencer.md
Name: brew_sequencer

Overview:
- Controller that sequences the brew datapath for one drink order: sensor check, pressurization, heating, delivery, completion.
- Sits between the drink-selection FSM (start pulse plus drink code) and the pressure/heater/delivery outputs (RGB and LED bar drivers).
- Phase durations come from a slow tick enable produced by the existing divider.
- Aborts on sensor loss at any point and requests a refund.

Parameters:
- CNT_W, 4, width of the phase timer in ticks
- PRESS_T, 3, pressurization duration in ticks, all drinks
- HEAT_T0, 2, heat duration for drink code 0
- HEAT_T1, 3, heat duration for drink code 1
- HEAT_T2, 4, heat duration for drink code 2
- HEAT_T3, 5, heat duration for drink code 3
- DELIV_T, 4, delivery duration in ticks, all drinks

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- tick  in  1  one-clk enable pulse per time unit, from the divider
- start  in  1  one-clk order pulse from the selection FSM
- drink  in  2  drink code; sampled only on an accepted start
- water_ok  in  1  water sensor OK
- grain_ok  in  1  coffee sensor OK
- cup_ok  in  1  cup sensor OK
- fault_clr  in  1  one-clk operator acknowledge that leaves FAULT
- busy  out  1  high in any state other than IDLE
- press_on  out  1  pressurization active
- heat_on  out  1  heater active
- deliver_on  out  1  delivery active (drives the LED bar)
- done  out  1  one-clk pulse at completion
- refund  out  1  one-clk pulse on abort
- fault  out  1  high while in FAULT
- state  out  3  encoded state, for display decode

Behaviour:
- Clock and reset
  - Single clock domain.
  - rst is sampled on the clk rising edge and dominates all other inputs.
  - Reset values: state=IDLE, timer=0, drink_q=0, every output 0.
- State encoding: IDLE=0, CHECK=1, PRESS=2, HEAT=3, DELIVER=4, DONE=5, FAULT=6. Code 7 is illegal and goes to IDLE on the next clk.
- sens_ok = water_ok & grain_ok & cup_ok.
- IDLE
  - start=1: latch drink into drink_q, go to CHECK.
  - All other inputs are ignored.
- CHECK (lasts exactly 1 clk)
  - sens_ok=1: go to PRESS and load timer=PRESS_T.
  - sens_ok=0: go to FAULT and pulse refund in the same transition clk.
- PRESS, HEAT, DELIVER
  - The matching output is high for the whole state and is a registered decode of the state.
  - On tick, timer decrements.
  - When tick=1 and timer==1:
    - PRESS goes to HEAT and loads HEAT_T[drink_q].
    - HEAT goes to DELIVER and loads DELIV_T.
    - DELIVER goes to DONE.
  - A phase therefore lasts exactly N ticks after entry.
  - A load value of 0 is forced to 1, so no phase is ever skipped.
- Sensor abort
  - In PRESS or HEAT, sens_ok=0 sends the block to FAULT on the next clk and pulses refund.
  - This is checked before the timer: when sens_ok drop and timer expiry coincide, FAULT wins.
  - In DELIVER, only cup_ok=0 aborts (water and grain have already been consumed).
  - The refund pulse still applies in DELIVER.
- DONE (lasts exactly 1 clk)
  - done=1, then go to IDLE.
- FAULT
  - fault=1, all actuator outputs 0.
  - fault_clr=1 with sens_ok=1: go to IDLE.
  - fault_clr=1 with sens_ok=0: stay in FAULT.
- start while busy is ignored, with no queueing.
- start and fault_clr together while in FAULT: only fault_clr acts; the start is dropped.
- drink may change freely after start; only drink_q is used.
- rst mid-brew: all actuators are 0 on the clk after rst and no refund pulse is issued. Refund on power-fail is the money path's job.
- Output exclusivity: at most one of press_on, heat_on, deliver_on is high in any cycle. Verification asserts this.
- The timer never underflows. It holds its value when tick=0 and when in a non-timed state.

Decomposition:
- Shared package brew_pkg holds:
  - the state encoding constants;
  - the drink code constants: 0 espresso, 1 long, 2 milk, 3 double;
  - the default phase durations.
- One natural sub-module, phase_timer:
  - load/value/tick inputs;
  - expire output (tick & count==1);
  - zero-forced-to-1 load.
- The FSM and output registers stay in brew_sequencer.

Test Plan:
- Nominal brew: all sensors OK, start with drink=2, tick every 4 clk -> press_on for 3 ticks, heat_on for 4 ticks, deliver_on for 4 ticks, then one-clk done, busy low again; refund never pulses.
- Sensor missing at order: cup_ok=0 at start -> CHECK then FAULT; refund pulses once, actuator outputs stay 0, fault=1; fault_clr with cup_ok still 0 keeps FAULT; after cup_ok=1, fault_clr returns to IDLE.
- Mid-heat abort: water_ok falls in the second heat tick of drink=3 -> heat_on low on the next clk, refund pulse, FAULT; with the drop coinciding with timer expiry, FAULT is still taken, never DELIVER.
- Start while busy: second start with drink=0 during PRESS of drink=1 -> ignored; heat lasts 3 ticks (HEAT_T1); no second done.
- Reset mid-delivery: rst high for 1 clk during DELIVER -> next clk state=0, all outputs 0, no refund or done; a fresh start afterwards brews normally.
- Override test (HEAT_T0=0, drink=0) -> heat_on lasts 1 tick; the exclusivity assertion holds across a full random tick/sensor run.
